// File: rtl/decoder_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : decoder_rr_arbiter4
// Description : Round-robin arbiter that owns a shared 2-to-4 decoder bank.
//               It drives the decoder selects and enable, and presents a
//               registered one-hot grant.
// Revision    : 1.0  initial release
// ============================================================================
module decoder_rr_arbiter4 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       A,
  output logic       B,
  output logic       enable,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold;
  logic [1:0]       r_sel;
  logic             r_en;
  logic [3:0]       r_gnt;
  logic             r_busy;

  logic [1:0] w_win;
  logic [1:0] w_own;
  logic [3:0] w_others;
  logic       w_any;
  logic       w_release;
  logic       w_timeout;

  // Rotating priority search: the lowest offset from r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[2'(r_ptr + 2'(i))]) begin
        w_win = 2'(r_ptr + 2'(i));
      end
    end
  end

  assign w_any     = |req;
  assign w_own     = r_sel;
  assign w_others  = req & ~(4'b0001 << w_own);
  assign w_release = ~req[w_own];
  assign w_timeout = (r_hold == c_HOLD_LAST) && (|w_others);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_hold  <= '0;
      r_sel   <= 2'd0;
      r_en    <= 1'b0;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_sel   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_en    <= 1'b1;
            r_hold  <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
          end
        end
        S_GRANT: begin
          if (w_release || w_timeout) begin
            // Break-before-make: selects hold, enable drops for one cycle.
            r_state <= S_GAP;
            r_en    <= 1'b0;
            r_gnt   <= 4'b0000;
            r_ptr   <= w_own + 2'd1;
            r_busy  <= 1'b1;
          end else if (r_hold != c_HOLD_LAST) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= 2'd0;
          r_en    <= 1'b0;
          r_gnt   <= 4'b0000;
          r_hold  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign A      = r_sel[1];
  assign B      = r_sel[0];
  assign enable = r_en;
  assign gnt    = r_gnt;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_rr_arbiter4
// Description : Directed scoreboard bench for decoder_rr_arbiter4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       A;
  logic       B;
  logic       enable;
  logic [3:0] gnt;
  logic       busy;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] ab;
    logic       en;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  decoder_rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .A      (A),
    .B      (B),
    .enable (enable),
    .gnt    (gnt),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] g, input logic [1:0] ab,
                      input logic en, input logic bz);
    exp_t e;
    e.tag  = tag;
    e.gnt  = g;
    e.ab   = ab;
    e.en   = en;
    e.busy = bz;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      cmp("scoreboard_empty", 8'h00, 8'h01);
      return;
    end
    e = q.pop_front();
    cmp(e.tag, {gnt, A, B, enable, busy}, {e.gnt, e.ab, e.en, e.busy});
    cmp({e.tag, "_onehot0"}, {7'd0, $onehot0(gnt)}, 8'h01);
    cmp({e.tag, "_gnt_iff_en"}, {7'd0, (gnt != 4'b0000)}, {7'd0, enable});
    if (enable) cmp({e.tag, "_gnt_sel"}, {4'd0, gnt}, {4'd0, 4'b0001 << {A, B}});
  endtask

  // Drive req, record the expected post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] ab, input logic en, input logic bz);
    req = r;
    push(tag, g, ab, en, bz);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic expect_now(input string tag, input logic [3:0] g, input logic [1:0] ab,
                            input logic en, input logic bz);
    push(tag, g, ab, en, bz);
    pop_check();
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("reset_async", 4'b0000, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("reset_hold", 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
    req   = 4'b0000;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("post_reset_idle", 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    step("single_grant", 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1);
    step("single_gap",   4'b0000, 4'b0000, 2'b10, 1'b0, 1'b1);
    step("single_idle",  4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0);

    // ptr is now 3: search order 3,0,1,2.
    step("wrap_grant0", 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b1);
    step("wrap_gap",    4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
    step("wrap_idle",   4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) step("solo_hold", 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1);
    step("solo_gap",  4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
    step("solo_idle", 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    expect_now("reset_pulse", 4'b0000, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) step("cont_g0", 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b1);
    step("cont_gap0", 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("cont_g1", 4'b1111, 4'b0010, 2'b01, 1'b1, 1'b1);
    step("cont_gap1", 4'b1111, 4'b0000, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("cont_g2", 4'b1111, 4'b0100, 2'b10, 1'b1, 1'b1);
    step("cont_gap2", 4'b1111, 4'b0000, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("cont_g3", 4'b1111, 4'b1000, 2'b11, 1'b1, 1'b1);
    step("cont_gap3", 4'b1111, 4'b0000, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("cont_g0_again", 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b1);

    step("midrst_gap",   4'b0010, 4'b0000, 2'b00, 1'b0, 1'b1);
    step("midrst_grant", 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("midrst_async", 4'b0000, 2'b00, 1'b0, 1'b0);
    req = 4'b0011;
    #1;
    rst_n = 1'b1;
    step("midrst_regrant", 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
